vx_tcu_tfr_pipe_ctrl: RTL

Valid/stall sequencer for a DEPTH-stage TFR tensor-core datapath built from single-depth shared/per-lane pipe registers. It tracks per-stage occupancy and generates the per-stage register enables and per-stage lane masks, so stages with no valid data do not load. It collapses bubbles and presents a valid/ready handshake at both ends. It sits between the TCU issue logic and the TFR datapath stages.

---
 rtl/vx_tcu_tfr_pipe_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/vx_tcu_tfr_pipe_ctrl.sv
// vx_tcu_tfr_pipe_ctrl: valid/stall sequencer for a DEPTH-stage TFR tensor-core pipe.
// Ports:
//   clk, reset (async, active-low), flush (sync kill of all in-flight stages)
//   valid_in/lane_mask_in/ready_in     : upstream handshake and item lane mask
//   valid_out/lane_mask_out/ready_out  : downstream handshake from the last stage
//   stage_en, stage_lane_mask          : per-stage datapath register enable and lane mask
//   stage_valid, count, busy           : occupancy status
module vx_tcu_tfr_pipe_ctrl #(
    parameter int DEPTH     = 3,
    parameter int NUM_LANES = 4,
    parameter int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           valid_in,
    input  logic [NUM_LANES-1:0]           lane_mask_in,
    output logic                           ready_in,
    output logic                           valid_out,
    output logic [NUM_LANES-1:0]           lane_mask_out,
    input  logic                           ready_out,
    output logic [DEPTH-1:0]               stage_en,
    output logic [DEPTH*NUM_LANES-1:0]     stage_lane_mask,
    output logic [DEPTH-1:0]               stage_valid,
    output logic [CNTW-1:0]                count,
    output logic                           busy
);
    logic [DEPTH-1:0]                 v;
    logic [DEPTH-1:0]                 v_next;
    logic [DEPTH-1:0]                 adv;
    logic [DEPTH-1:0]                 pv;
    logic [DEPTH-1:0][NUM_LANES-1:0]  m;
    logic [DEPTH-1:0][NUM_LANES-1:0]  pm;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        // A stage can advance when it or any stage after it is empty, or the sink drains;
        // written flat instead of as a ripple chain so the vector has no self-dependency.
        assign adv[g] = ready_out | ~(&v[DEPTH-1:g]);
        if (g == 0) begin : g_head
            assign pv[g] = valid_in & ~flush;
            assign pm[g] = lane_mask_in;
        end else begin : g_body
            assign pv[g] = v[g-1];
            assign pm[g] = m[g-1];
        end
    end

    assign stage_en        = adv & pv & {DEPTH{~flush}};
    assign v_next          = flush ? '0 : (adv & pv) | (~adv & v);
    assign stage_lane_mask = pm;
    assign stage_valid     = v;
    assign ready_in        = adv[0] & ~flush;
    assign valid_out       = v[DEPTH-1] & ~flush;
    assign lane_mask_out   = valid_out ? m[DEPTH-1] : '0;
    assign busy            = count != '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v     <= '0;
            m     <= '0;
            count <= '0;
        end else begin
            v     <= v_next;
            count <= CNTW'($countones(v_next));
            for (int i = 0; i < DEPTH; i++)
                if (stage_en[i]) m[i] <= pm[i];
        end
    end
endmodule
